// File: rtl/cdi_bus_pkg.sv
// Shared types and constants for the video word-fetch responder and its arbiter.
package cdi_bus_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 16;

    // Clears bit 0 of a byte address; sliced down to the port width by users.
    localparam logic [63:0] WORD_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFE;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        PREF
    } fetch_state_e;

    typedef logic ch_idx_t;

endpackage

// File: rtl/fetch_rr_arbiter.sv
// Two-channel round-robin pick; the caller owns and registers last_grant.
module fetch_rr_arbiter
    import cdi_bus_pkg::*;
(
    input  logic [1:0] req,
    input  ch_idx_t    last_grant,
    output logic       gnt_valid,
    output ch_idx_t    gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/video_fetch_responder.sv
// Serves two word-fetch requesters from one memory read port, one read in flight.
// Optional single-entry next-word prefetch buffer: define VIDEO_FETCH_PREFETCH_EN.
//
// state | meaning
// IDLE  | arbitrate ch_as, latch granted channel and word address
// ISSUE | mem_rd held until mem_ready
// WAIT  | waiting for mem_rvalid; ack only if the requester still holds as
// ACK   | one-cycle ch_bus_ack pulse, last_grant updated
// PREF  | speculative read of the next word (prefetch build only)
module video_fetch_responder
    import cdi_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH-1:0]        ch_as,
    output logic [NUM_CH*DATA_W-1:0] ch_din,
    output logic [NUM_CH-1:0]        ch_bus_ack,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rvalid
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = WORD_ALIGN_MASK[ADDR_W-1:0];

    fetch_state_e             state_q, state_d;
    ch_idx_t                  grant_q, grant_d;
    ch_idx_t                  last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic                     mem_rd_q, mem_rd_d;
    logic [NUM_CH*DATA_W-1:0] ch_din_q, ch_din_d;
    logic [NUM_CH-1:0]        ack_q, ack_d;

    logic                     gnt_valid;
    ch_idx_t                  gnt_idx;
    logic [ADDR_W-1:0]        req_addr;
    logic                     pref_active;

`ifdef VIDEO_FETCH_PREFETCH_EN
    logic                     pref_q, pref_d;
    logic                     buf_valid_q, buf_valid_d;
    ch_idx_t                  buf_ch_q, buf_ch_d;
    logic [ADDR_W-1:0]        buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]        buf_data_q, buf_data_d;
    logic                     buf_hit;

    assign pref_active = pref_q;
`else
    assign pref_active = 1'b0;
`endif

    fetch_rr_arbiter u_arb (
        .req        (ch_as),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign req_addr = ch_address[int'(gnt_idx)*ADDR_W +: ADDR_W] & ALIGN_MASK;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = mem_rd_q;
        ch_din_d     = ch_din_q;
        ack_d        = '0;
`ifdef VIDEO_FETCH_PREFETCH_EN
        pref_d       = pref_q;
        buf_valid_d  = buf_valid_q;
        buf_ch_d     = buf_ch_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        buf_hit      = buf_valid_q && gnt_valid && (buf_ch_q == gnt_idx)
                       && (buf_addr_q == req_addr);
        // The prefetched word only belongs to an uninterrupted burst.
        if (buf_valid_q && !ch_as[buf_ch_q]) begin
            buf_valid_d = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d    = gnt_idx;
                    mem_addr_d = req_addr;
`ifdef VIDEO_FETCH_PREFETCH_EN
                    buf_valid_d = 1'b0;
                    if (buf_hit) begin
                        ch_din_d[int'(gnt_idx)*DATA_W +: DATA_W] = buf_data_q;
                        ack_d[gnt_idx] = 1'b1;
                        state_d        = ACK;
                    end else begin
                        mem_rd_d = 1'b1;
                        state_d  = ISSUE;
                    end
`else
                    mem_rd_d = 1'b1;
                    state_d  = ISSUE;
`endif
                end
            end

            ISSUE: begin
                if (mem_ready) begin
                    mem_rd_d = 1'b0;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (pref_active) begin
`ifdef VIDEO_FETCH_PREFETCH_EN
                        pref_d = 1'b0;
                        if (ch_as[grant_q]) begin
                            buf_valid_d = 1'b1;
                            buf_ch_d    = grant_q;
                            buf_addr_d  = mem_addr_q;
                            buf_data_d  = mem_rdata;
                        end
`endif
                    end else if (ch_as[grant_q]) begin
                        ch_din_d[int'(grant_q)*DATA_W +: DATA_W] = mem_rdata;
                        ack_d[grant_q] = 1'b1;
                        state_d        = ACK;
                    end
                end
            end

            ACK: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
`ifdef VIDEO_FETCH_PREFETCH_EN
                if (ch_as[grant_q]) begin
                    mem_addr_d = mem_addr_q + ADDR_W'(2);
                    mem_rd_d   = 1'b1;
                    pref_d     = 1'b1;
                    state_d    = PREF;
                end
`endif
            end

            PREF: begin
`ifdef VIDEO_FETCH_PREFETCH_EN
                if (mem_ready) begin
                    mem_rd_d = 1'b0;
                    state_d  = WAIT;
                end
`else
                state_d = IDLE;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            ch_din_q     <= '0;
            ack_q        <= '0;
`ifdef VIDEO_FETCH_PREFETCH_EN
            pref_q       <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_ch_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            ch_din_q     <= ch_din_d;
            ack_q        <= ack_d;
`ifdef VIDEO_FETCH_PREFETCH_EN
            pref_q       <= pref_d;
            buf_valid_q  <= buf_valid_d;
            buf_ch_q     <= buf_ch_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
`endif
        end
    end

    assign ch_din     = ch_din_q;
    assign ch_bus_ack = ack_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;

endmodule

// File: tb/tb_video_fetch_responder.sv
// Directed bench for video_fetch_responder with a latency-programmable memory model.
`timescale 1ns/1ps
module tb_video_fetch_responder;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int NUM_CH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NUM_CH*ADDR_W-1:0] ch_address = '0;
    logic [NUM_CH-1:0]        ch_as = '0;
    logic [NUM_CH*DATA_W-1:0] ch_din;
    logic [NUM_CH-1:0]        ch_bus_ack;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_rd;
    logic                     mem_ready;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_rvalid;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rv_delay = 1;
    logic [15:0] mem_img [int];

    int          log_n = 0;
    int          log_ch [64];
    logic [15:0] log_data [64];
    int          log_cyc [64];
    int          iss_n = 0;
    logic [21:0] iss_addr [64];
    int          iss_cyc [64];

    video_fetch_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_address (ch_address),
        .ch_as      (ch_as),
        .ch_din     (ch_din),
        .ch_bus_ack (ch_bus_ack),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: accepts whenever mem_rd is high, answers rv_delay cycles after accept.
    initial begin
        int cnt;
        logic [15:0] pend;
        cnt = 0;
        pend = '0;
        mem_ready = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_rd && mem_ready) begin
                pend = mem_img.exists(int'(mem_addr)) ? mem_img[int'(mem_addr)] : 16'hDEAD;
                cnt = rv_delay;
            end
            @(posedge clk);
            #1;
            if (cnt == 1) begin
                mem_rvalid = 1'b1;
                mem_rdata = pend;
            end else begin
                mem_rvalid = 1'b0;
            end
            if (cnt > 0) cnt--;
        end
    end

    // Logs every ack and every new memory read with the cycle it was seen in.
    initial begin
        logic rd_prev;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_bus_ack[c] && log_n < 64) begin
                    log_ch[log_n] = c;
                    log_data[log_n] = ch_din[c*DATA_W +: DATA_W];
                    log_cyc[log_n] = cyc;
                    log_n++;
                end
            end
            if (mem_rd && !rd_prev && iss_n < 64) begin
                iss_addr[iss_n] = mem_addr;
                iss_cyc[iss_n] = cyc;
                iss_n++;
            end
            rd_prev = mem_rd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_n = 0;
        iss_n = 0;
    endtask

    task automatic set_ch(input int c, input logic [21:0] a, input logic as_v);
        ch_address[c*ADDR_W +: ADDR_W] = a;
        ch_as[c] = as_v;
    endtask

    // Fetcher model: after each ack the channel steps its address by one word.
    task automatic run_fetchers(input int n_target, input int budget);
        int seen;
        int c;
        seen = log_n;
        for (int i = 0; i < budget; i++) begin
            tick();
            while (seen < log_n) begin
                c = log_ch[seen];
                ch_address[c*ADDR_W +: ADDR_W] = ch_address[c*ADDR_W +: ADDR_W] + 22'd2;
                seen++;
            end
            if (log_n >= n_target) break;
        end
        ch_as = '0;
    endtask

    task automatic wait_acks(input int n, input int budget);
        for (int i = 0; i < budget && log_n < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ch_as = '0;
        ch_address = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        tests_run++;
        if (ch_din !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_din: got %h want %h", ch_din, 32'h0);
        end
        tests_run++;
        if (ch_bus_ack !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ack: got %b want %b", ch_bus_ack, 2'b00);
        end
        tests_run++;
        if (mem_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_rd: got %b want %b", mem_rd, 1'b0);
        end
        tests_run++;
        if (mem_addr !== 22'h0) begin
            tests_failed++;
            $display("FAIL reset_mem_addr: got %h want %h", mem_addr, 22'h0);
        end
    endtask

    task automatic test_contention();
        int c0;
        int exp_ch [4];
        logic [15:0] exp_data [4];
        int exp_off [4];
        logic [21:0] exp_iss [4];
        exp_ch = '{0, 1, 0, 1};
        exp_data = '{16'h1000, 16'h2004, 16'h1002, 16'h2006};
        exp_off = '{3, 7, 11, 15};
        exp_iss = '{22'h400, 22'h404, 22'h402, 22'h406};
        mem_img[32'h400] = 16'h1000;
        mem_img[32'h402] = 16'h1002;
        mem_img[32'h404] = 16'h2004;
        mem_img[32'h406] = 16'h2006;
        clear_logs();
        set_ch(0, 22'h400, 1'b1);
        set_ch(1, 22'h404, 1'b1);
        c0 = cyc;
        run_fetchers(4, 40);
        tests_run++;
        if (log_n !== 4) begin
            tests_failed++;
            $display("FAIL contention_count: got %0d acks want %0d", log_n, 4);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (log_ch[i] !== exp_ch[i] || log_data[i] !== exp_data[i] || log_cyc[i] !== c0 + exp_off[i]) begin
                tests_failed++;
                $display("FAIL contention_ack%0d: got ch%0d %h @%0d want ch%0d %h @%0d", i,
                         log_ch[i], log_data[i], log_cyc[i] - c0, exp_ch[i], exp_data[i], exp_off[i]);
            end
            tests_run++;
            if (iss_addr[i] !== exp_iss[i]) begin
                tests_failed++;
                $display("FAIL contention_addr%0d: got %h want %h", i, iss_addr[i], exp_iss[i]);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_single();
        int c0;
        mem_img[32'h400] = 16'hA5C3;
        clear_logs();
        set_ch(0, 22'h400, 1'b1);
        c0 = cyc;
        run_fetchers(1, 20);
        tests_run++;
        if (log_ch[0] !== 0 || log_cyc[0] !== c0 + 3 || log_data[0] !== 16'hA5C3) begin
            tests_failed++;
            $display("FAIL single_ack: got ch%0d %h @%0d want ch0 a5c3 @3",
                     log_ch[0], log_data[0], log_cyc[0] - c0);
        end
        tests_run++;
        if (iss_addr[0] !== 22'h400 || iss_cyc[0] !== c0 + 1) begin
            tests_failed++;
            $display("FAIL single_issue: got %h @%0d want 000400 @1", iss_addr[0], iss_cyc[0] - c0);
        end
        tick();
        tests_run++;
        if (ch_bus_ack !== 2'b00 || log_n !== 1) begin
            tests_failed++;
            $display("FAIL single_pulse: got ack %b count %0d want ack 00 count 1", ch_bus_ack, log_n);
        end
        tests_run++;
        if (ch_din !== 32'h2006_A5C3 || mem_addr !== 22'h400) begin
            tests_failed++;
            $display("FAIL single_hold: got din %h addr %h want 2006a5c3 000400", ch_din, mem_addr);
        end
    endtask

    task automatic test_burst();
        int c0;
        mem_img[32'h400] = 16'h1234;
        mem_img[32'h402] = 16'h5678;
        clear_logs();
        set_ch(0, 22'h400, 1'b1);
        c0 = cyc;
        run_fetchers(2, 30);
        tick();
        tests_run++;
        if (log_n !== 2 || ch_bus_ack !== 2'b00) begin
            tests_failed++;
            $display("FAIL burst_count: got %0d acks, ack now %b want 2, 00", log_n, ch_bus_ack);
        end
        tests_run++;
        if (log_data[0] !== 16'h1234 || log_cyc[0] !== c0 + 3) begin
            tests_failed++;
            $display("FAIL burst_first: got %h @%0d want 1234 @3", log_data[0], log_cyc[0] - c0);
        end
        tests_run++;
        if (log_data[1] !== 16'h5678 || log_cyc[1] !== c0 + 7 || iss_addr[1] !== 22'h402) begin
            tests_failed++;
            $display("FAIL burst_second: got %h @%0d addr %h want 5678 @7 addr 000402",
                     log_data[1], log_cyc[1] - c0, iss_addr[1]);
        end
    endtask

    task automatic test_abort();
        int c0;
        rv_delay = 4;
        mem_img[32'h408] = 16'hBEEF;
        mem_img[32'h40A] = 16'h7777;
        clear_logs();
        set_ch(1, 22'h408, 1'b1);
        c0 = cyc;
        repeat (3) tick();
        set_ch(1, 22'h408, 1'b0);
        set_ch(0, 22'h40A, 1'b1);
        run_fetchers(1, 40);
        tick();
        tests_run++;
        if (log_n !== 1 || log_ch[0] !== 0) begin
            tests_failed++;
            $display("FAIL abort_acks: got %0d acks first ch%0d want 1 on ch0", log_n, log_ch[0]);
        end
        tests_run++;
        if (log_data[0] !== 16'h7777 || log_cyc[0] !== c0 + 12) begin
            tests_failed++;
            $display("FAIL abort_next: got %h @%0d want 7777 @12", log_data[0], log_cyc[0] - c0);
        end
        tests_run++;
        if (ch_din[31:16] !== 16'h2006) begin
            tests_failed++;
            $display("FAIL abort_din1: got %h want %h", ch_din[31:16], 16'h2006);
        end
        tests_run++;
        if (iss_addr[1] !== 22'h40A || iss_cyc[1] !== c0 + 7) begin
            tests_failed++;
            $display("FAIL abort_issue: got %h @%0d want 00040a @7", iss_addr[1], iss_cyc[1] - c0);
        end
        rv_delay = 1;
    endtask

    task automatic test_reset_mid();
        int c1;
        rv_delay = 4;
        mem_img[32'h40C] = 16'hCCCC;
        clear_logs();
        set_ch(0, 22'h40C, 1'b1);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (ch_din !== 32'h0 || ch_bus_ack !== 2'b00 || mem_rd !== 1'b0 || mem_addr !== 22'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got din %h ack %b rd %b addr %h want all zero",
                     ch_din, ch_bus_ack, mem_rd, mem_addr);
        end
        ch_as = '0;
        repeat (4) tick();
        reset_n = 1'b1;
        rv_delay = 1;
        mem_img[32'h410] = 16'h0A0A;
        mem_img[32'h412] = 16'h0B0B;
        tick();
        tests_run++;
        if (log_n !== 0 || mem_rd !== 1'b0 || ch_din !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_stray: got %0d acks rd %b din %h want 0 0 0", log_n, mem_rd, ch_din);
        end
        set_ch(0, 22'h410, 1'b1);
        set_ch(1, 22'h412, 1'b1);
        c1 = cyc;
        run_fetchers(2, 30);
        tests_run++;
        if (log_ch[0] !== 0 || log_data[0] !== 16'h0A0A || log_cyc[0] !== c1 + 3) begin
            tests_failed++;
            $display("FAIL midreset_first: got ch%0d %h @%0d want ch0 0a0a @3",
                     log_ch[0], log_data[0], log_cyc[0] - c1);
        end
        tests_run++;
        if (log_ch[1] !== 1 || log_data[1] !== 16'h0B0B || log_cyc[1] !== c1 + 7) begin
            tests_failed++;
            $display("FAIL midreset_second: got ch%0d %h @%0d want ch1 0b0b @7",
                     log_ch[1], log_data[1], log_cyc[1] - c1);
        end
        repeat (2) tick();
    endtask

`ifdef VIDEO_FETCH_PREFETCH_EN
    task automatic test_prefetch();
        int c0;
        mem_img[32'h400] = 16'h1111;
        mem_img[32'h402] = 16'h2222;
        mem_img[32'h404] = 16'h3333;
        mem_img[32'h500] = 16'h5005;
        clear_logs();
        set_ch(0, 22'h400, 1'b1);
        c0 = cyc;
        wait_acks(1, 20);
        set_ch(0, 22'h402, 1'b1);
        wait_acks(2, 20);
        set_ch(0, 22'h500, 1'b1);
        wait_acks(3, 30);
        ch_as = '0;
        repeat (4) tick();
        tests_run++;
        if (iss_addr[1] !== 22'h402 || iss_cyc[1] !== c0 + 4) begin
            tests_failed++;
            $display("FAIL pref_issue: got %h @%0d want 000402 @4", iss_addr[1], iss_cyc[1] - c0);
        end
        tests_run++;
        if (log_data[1] !== 16'h2222 || log_cyc[1] !== c0 + 7) begin
            tests_failed++;
            $display("FAIL pref_hit: got %h @%0d want 2222 @7", log_data[1], log_cyc[1] - c0);
        end
        tests_run++;
        if (log_data[2] !== 16'h5005 || log_cyc[2] !== c0 + 13 || iss_addr[3] !== 22'h500) begin
            tests_failed++;
            $display("FAIL pref_miss: got %h @%0d addr %h want 5005 @13 addr 000500",
                     log_data[2], log_cyc[2] - c0, iss_addr[3]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_burst();
        test_abort();
        test_reset_mid();
`ifdef VIDEO_FETCH_PREFETCH_EN
        test_prefetch();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/video_fetch_responder.md
Name: video_fetch_responder

Overview:
- Memory-side responder for the video controller's word-fetch bus (address/as/din/bus_ack), as used by the ICA/DCA instruction fetchers.
- Serves two requester channels (odd/even field fetchers) from one shared memory read port.
- Channels are granted round-robin, with one outstanding memory read at a time.
- Returns each word on a registered din together with a single-cycle bus_ack pulse.

Parameters:
- ADDR_W, 22, byte address width of requester and memory port
- DATA_W, 16, word width
- NUM_CH, 2, requester channels; fixed at 2, index 0 wins the first arbitration after reset

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ch_address  in  NUM_CH x ADDR_W  per-channel word address; bit 0 ignored
- ch_as  in  NUM_CH  per-channel address strobe; level-held across multi-word bursts
- ch_din  out  NUM_CH x DATA_W  per-channel returned word
- ch_bus_ack  out  NUM_CH  per-channel one-cycle acknowledge; data is valid in this cycle
- mem_addr  out  ADDR_W  memory read address, word aligned
- mem_rd  out  1  read request, held until accepted
- mem_ready  in  1  memory accepts the request this cycle
- mem_rdata  in  DATA_W  read data
- mem_rvalid  in  1  read data valid, exactly one pulse per accepted read

Behaviour:
- Reset, asynchronous: all ch_din=0, ch_bus_ack=0, mem_rd=0, mem_addr=0, state=IDLE, last_grant=1 (so channel 0 is favoured first).
- States:
  - IDLE: samples ch_as.
    - No request: stay.
    - One request: grant it.
    - Both request: grant the channel that is not last_grant.
    - On grant: latch the channel and {address[ADDR_W-1:1],1'b0} into mem_addr, set mem_rd=1, go to ISSUE.
  - ISSUE: mem_rd=1. On mem_ready: mem_rd<=0, go to WAIT.
  - WAIT: on mem_rvalid, latch mem_rdata. If the granted channel's as is still high, go to ACK; otherwise go to IDLE (abort, no ack, ch_din unchanged).
  - ACK: ch_din[g]=latched data and ch_bus_ack[g]=1 for exactly one cycle; last_grant<=g; go to IDLE.
- Requesters update their address the cycle after ack. IDLE always follows ACK, so the new address is sampled without a gap cycle.
- ch_as is never sampled during the ACK cycle.
- Latency, zero-wait memory (mem_ready=1, mem_rvalid one cycle after accept): as seen at cycle 0, ISSUE at 1, rvalid at 2, ack at 3.
- ch_din holds its last value between acks. A non-granted channel's ack stays 0.
- mem_rvalid outside WAIT is ignored, e.g. a response in flight across a reset.
- as dropping in ISSUE: the memory read still completes; the result is discarded in WAIT.
- Addresses wrap modulo 2^ADDR_W; there is no range check.
- Fairness: while both channels request continuously, grants alternate 0,1,0,1.

Optional Feature:
- Macro: VIDEO_FETCH_PREFETCH_EN.
- With the macro:
  - After ACK, if the granted channel's as is still high, enter PREF: issue a read of mem_addr+2 through the same ISSUE/WAIT path without acking, and store the result in a single buffer tagged {channel, address}.
  - In IDLE, a request whose channel and address match a valid tag goes directly to ACK next cycle, giving 1-cycle latency; the buffer is then invalidated.
  - A mismatching request invalidates the buffer and takes the normal path.
  - The buffer is invalidated by reset or by the tagged channel's as falling.
  - The other channel may wait for the prefetch to complete, so the maximum blocking is one extra memory read.
- Without the macro: no PREF state and no buffer; behaviour is exactly as above.

Decomposition:
- Package cdi_bus_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, ACK, PREF)
  - channel index typedef
  - ADDR_W and DATA_W defaults
  - the word-alignment mask constant
- One sub-module, fetch_rr_arbiter:
  - inputs: request vector, last_grant
  - outputs: grant valid, grant index
  - combinational with a registered last_grant owned by the parent

Test Plan:
- Single word: ch0 as=1, address 0x000400, memory returns 0xA5C3 one cycle after accept → ch_bus_ack[0] pulses exactly at cycle 3, ch_din[0]=0xA5C3, mem_addr=0x000400.
- Two-word burst, fetcher model: ch0 reads 0x400 then 0x402, memory 0x1234/0x5678 → two acks, each one cycle, data in order, no gap cycle beyond latency.
- Contention: both channels hold as continuously, ch0 at 0x400 and ch1 at 0x404 → grant order 0,1,0,1; mem_addr alternates between channel streams.
- Abort: ch1 drops as while in WAIT with mem_rvalid 4 cycles late → no ack on ch1, ch_din[1] unchanged, next IDLE serves ch0.
- Reset mid-transaction: reset_n low during WAIT with rvalid arriving during reset → all outputs 0 immediately, stray rvalid ignored, first post-reset grant is ch0.
- PREFETCH_EN: ch0 burst 0x400, 0x402 → second ack arrives 1 cycle after address update; a jump to 0x500 invalidates the buffer and uses normal latency.
